// File: rtl/pcileech_pcie_bar_rdwr.sv
// BAR responder: MRd32/MWr32 snooped from the 64-bit RX stream hit a DW register file; MRd32 queues 4-DW completions.
// Latency: completion pushed 2 edges after the last request beat; MWr32 lands 1 edge after (`define PCILEECH_BAR_MWR_EN).
// Backpressure: RX is never stalled; completions that find the FIFO full are dropped and counted.
module pcileech_pcie_bar_rdwr #(
  parameter int ADDR_W         = 8,
  parameter int CPL_DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [63:0]         rx_data,
  input  logic [7:0]          rx_keep,
  input  logic                rx_last,
  input  logic                rx_valid,
  input  logic                rx_ready,
  input  logic [15:0]         pcie_id,
  input  logic [31:0]         bar_base,
  input  logic [31:0]         bar_mask,
  input  logic                hwr_en,
  input  logic [ADDR_W-1:0]   hwr_addr,
  input  logic [31:0]         hwr_data,
  output logic                tx_has_data,
  input  logic                tx_req_data,
  output logic                tx_valid,
  output logic [131:0]        tx_data,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [1:0] {HDR0, HDR1, SKIP} state_t;

  localparam int DEPTH = 1 << CPL_DEPTH_LOG2;

  state_t state, state_nxt;
  logic   beat;
  logic   hdr0_common, win_hit, rd_hit;

  logic        hdr_rd_ok;
  logic [15:0] req_id;
  logic [7:0]  tag;

  logic              rd_pend;
  logic [ADDR_W-1:0] rd_idx;
  logic [15:0]       rd_req_id;
  logic [7:0]        rd_tag;
  logic [4:0]        rd_lo;

  logic        cpl_pend;
  logic [31:0] cpl_dw2;
  logic [31:0] rd_q;

  logic [31:0] rf [2**ADDR_W];

  logic [63:0]               fifo_mem [DEPTH];
  logic [CPL_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CPL_DEPTH_LOG2:0]   count;
  logic                      fifo_full, push, pop;

`ifdef PCILEECH_BAR_MWR_EN
  logic              hdr_wr_ok, wr_hit, wr_pend;
  logic [3:0]        first_be, wr_be;
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       wr_dat;
`endif

  assign beat = rx_valid & rx_ready;

  // Field checks shared by MRd32 and MWr32, taken straight from the first beat.
  assign hdr0_common = (rx_data[23:20] == 4'd0) && !rx_data[14] && (rx_data[13:12] == 2'd0)
                    && (rx_data[9:0] == 10'd1) && (rx_data[39:36] == 4'd0);
  assign win_hit = (((rx_data[31:0] ^ bar_base) & ~bar_mask) == 32'd0);

  always_ff @(posedge clk) begin
    if (rst) state <= HDR0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_hit    = 1'b0;
`ifdef PCILEECH_BAR_MWR_EN
    wr_hit    = 1'b0;
`endif
    case (state)
      HDR0: if (beat && !rx_last) state_nxt = HDR1;
      HDR1: if (beat) begin
        if (rx_last) begin
          state_nxt = HDR0;
          rd_hit    = en && hdr_rd_ok && win_hit && (rx_keep == 8'h0F);
`ifdef PCILEECH_BAR_MWR_EN
          wr_hit    = en && hdr_wr_ok && win_hit && (rx_keep == 8'hFF);
`endif
        end else begin
          state_nxt = SKIP;
        end
      end
      SKIP: if (beat && rx_last) state_nxt = HDR0;
      default: state_nxt = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == HDR0 && beat) begin
      hdr_rd_ok <= hdr0_common && (rx_data[31:24] == 8'h00);
      req_id    <= rx_data[63:48];
      tag       <= rx_data[47:40];
`ifdef PCILEECH_BAR_MWR_EN
      hdr_wr_ok <= hdr0_common && (rx_data[31:24] == 8'h40) && (rx_data[35:32] != 4'd0);
      first_be  <= rx_data[35:32];
`endif
    end
    rd_idx    <= rx_data[ADDR_W+1:2];
    rd_req_id <= req_id;
    rd_tag    <= tag;
    rd_lo     <= rx_data[6:2];
    cpl_dw2   <= {rd_req_id, rd_tag, 1'b0, rd_lo, 2'b00};
`ifdef PCILEECH_BAR_MWR_EN
    wr_idx    <= rx_data[ADDR_W+1:2];
    wr_be     <= first_be;
    wr_dat    <= rx_data[63:32];
`endif
  end

  // Register file: read-first, host write overrides a same-index MWr32.
  always_ff @(posedge clk) begin
    rd_q <= rf[rd_idx];
`ifdef PCILEECH_BAR_MWR_EN
    if (wr_pend) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) rf[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
`endif
    if (hwr_en) rf[hwr_addr] <= hwr_data;
  end

  assign fifo_full   = (count == (CPL_DEPTH_LOG2+1)'(DEPTH));
  assign pop         = tx_req_data && (count != '0);
  assign push        = cpl_pend && (!fifo_full || pop);
  assign tx_has_data = (count != '0);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {rd_q, cpl_dw2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      cpl_pend <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      drop_cnt <= '0;
`ifdef PCILEECH_BAR_MWR_EN
      wr_pend  <= 1'b0;
`endif
    end else begin
      rd_pend  <= rd_hit;
      cpl_pend <= rd_pend;
`ifdef PCILEECH_BAR_MWR_EN
      wr_pend  <= wr_hit;
`endif
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      tx_valid <= pop;
      if (pop) tx_data <= {1'b1, 1'b1, fifo_mem[rd_ptr],
                           1'b1, 1'b0, pcie_id, 16'h0004, 32'h4A000001};
      if (cpl_pend && !push && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pcileech_pcie_bar_rdwr.sv
// Directed bench for pcileech_pcie_bar_rdwr: hit/miss decode, completion format, FIFO overflow, writes, reset.
module tb_pcileech_pcie_bar_rdwr;

  localparam logic [15:0] PCIE_ID = 16'hABCD;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b1;
  logic [63:0]  rx_data = '0;
  logic [7:0]   rx_keep = '0;
  logic         rx_last = 1'b0;
  logic         rx_valid = 1'b0;
  logic         rx_ready = 1'b1;
  logic [15:0]  pcie_id = PCIE_ID;
  logic [31:0]  bar_base = 32'hF000_0000;
  logic [31:0]  bar_mask = 32'h0000_03FF;
  logic         hwr_en = 1'b0;
  logic [7:0]   hwr_addr = '0;
  logic [31:0]  hwr_data = '0;
  logic         tx_has_data;
  logic         tx_req_data = 1'b0;
  logic         tx_valid;
  logic [131:0] tx_data;
  logic [15:0]  drop_cnt;

  int n_pass = 0;
  int n_total = 0;

  pcileech_pcie_bar_rdwr dut (
    .clk(clk), .rst(rst), .en(en),
    .rx_data(rx_data), .rx_keep(rx_keep), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pcie_id(pcie_id), .bar_base(bar_base), .bar_mask(bar_mask),
    .hwr_en(hwr_en), .hwr_addr(hwr_addr), .hwr_data(hwr_data),
    .tx_has_data(tx_has_data), .tx_req_data(tx_req_data), .tx_valid(tx_valid), .tx_data(tx_data),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tg, input logic [131:0] got, input logic [131:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tg, got, exp);
  endtask

  function automatic logic [131:0] cpl(input logic [31:0] dw3, input logic [15:0] rid,
                                       input logic [7:0] tg, input logic [31:0] addr);
    logic [31:0] dw2;
    dw2 = {rid, tg, 1'b0, addr[6:2], 2'b00};
    return {1'b1, 1'b1, dw3, dw2, 1'b1, 1'b0, PCIE_ID, 16'h0004, 32'h4A00_0001};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    rx_data = d; rx_keep = k; rx_last = l; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic mrd(input logic [31:0] addr, input logic [7:0] tg, input logic [31:0] dw0);
    beat({16'h0100, tg, 8'h0F, dw0}, 8'hFF, 1'b0);
    beat({32'h0, addr}, 8'h0F, 1'b1);
  endtask

  task automatic mwr(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] d);
    beat({16'h0100, 8'h00, 4'h0, be, 32'h4000_0001}, 8'hFF, 1'b0);
    beat({d, addr}, 8'hFF, 1'b1);
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    hwr_en = 1'b1; hwr_addr = a; hwr_data = d;
    @(posedge clk); #1;
    hwr_en = 1'b0;
  endtask

  task automatic pop_check(input string tg, input logic [131:0] exp);
    tx_req_data = 1'b1;
    @(posedge clk); #1;
    tx_req_data = 1'b0;
    check({tg, "_vld"}, {131'd0, tx_valid}, 132'd1);
    check(tg, tx_data, exp);
  endtask

  initial begin
    logic [31:0] exp_mwr;
    cycles(3);
    rst = 1'b0;
    check("rst_has_data", {131'd0, tx_has_data}, 132'd0);
    check("rst_valid", {131'd0, tx_valid}, 132'd0);
    check("rst_data", tx_data, 132'd0);
    check("rst_drop", {116'd0, drop_cnt}, 132'd0);

    // Basic read hit and completion layout
    host_wr(8'd5, 32'hDEAD_BEEF);
    mrd(32'hF000_0014, 8'h21, 32'h0000_0001);
    cycles(1);
    check("lat_t1", {131'd0, tx_has_data}, 132'd0);
    cycles(1);
    check("lat_t2", {131'd0, tx_has_data}, 132'd1);
    pop_check("cpl0", {2'b11, 32'hDEAD_BEEF, 32'h0100_2114, 2'b10, 32'hABCD_0004, 32'h4A00_0001});
    check("cpl0_dw3", {100'd0, tx_data[129:98]}, {100'd0, 32'hDEAD_BEEF});
    check("cpl0_dw2", {100'd0, tx_data[97:66]}, {100'd0, 32'h0100_2114});
    cycles(1);
    check("pulse_end", {131'd0, tx_valid}, 132'd0);
    check("drained", {131'd0, tx_has_data}, 132'd0);

    // Requests that must not decode
    mrd(32'hE000_0014, 8'h22, 32'h0000_0001);
    cycles(3);
    check("miss_addr", {131'd0, tx_has_data}, 132'd0);
    mrd(32'hF000_0014, 8'h23, 32'h0000_0002);
    cycles(3);
    check("miss_len2", {131'd0, tx_has_data}, 132'd0);
    mrd(32'hF000_0014, 8'h24, 32'h0000_4001);
    cycles(3);
    check("miss_ep", {131'd0, tx_has_data}, 132'd0);
    tx_req_data = 1'b1;
    cycles(1);
    tx_req_data = 1'b0;
    check("empty_pop", {131'd0, tx_valid}, 132'd0);

    // Overflow: five back-to-back reads into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) mrd(32'hF000_0014, 8'(i), 32'h0000_0001);
    cycles(3);
    check("ovf_has_data", {131'd0, tx_has_data}, 132'd1);
    check("ovf_drop", {116'd0, drop_cnt}, 132'd1);
    for (int i = 1; i <= 4; i++)
      pop_check($sformatf("ovf_pop%0d", i), cpl(32'hDEAD_BEEF, 16'h0100, 8'(i), 32'hF000_0014));
    cycles(1);
    check("ovf_empty", {131'd0, tx_has_data}, 132'd0);

    // Byte-enabled MWr32, then read back
    host_wr(8'd2, 32'hAAAA_AAAA);
    mwr(32'hF000_0008, 4'h3, 32'h1122_3344);
    cycles(3);
    check("mwr_no_cpl", {131'd0, tx_has_data}, 132'd0);
    mrd(32'hF000_0008, 8'h31, 32'h0000_0001);
    cycles(2);
`ifdef PCILEECH_BAR_MWR_EN
    exp_mwr = 32'hAAAA_3344;
`else
    exp_mwr = 32'hAAAA_AAAA;
`endif
    pop_check("mwr_rd", {2'b11, exp_mwr, 32'h0100_3108, 2'b10, 32'hABCD_0004, 32'h4A00_0001});

    // Host write collides with MWr32 on the same index
    mwr(32'hF000_000C, 4'hF, 32'h5555_5555);
    host_wr(8'd3, 32'h1234_5678);
    cycles(1);
    mrd(32'hF000_000C, 8'h32, 32'h0000_0001);
    cycles(2);
    pop_check("host_wins", cpl(32'h1234_5678, 16'h0100, 8'h32, 32'hF000_000C));

    // Reset between the two beats of a read
    beat({16'h0100, 8'h41, 8'h0F, 32'h0000_0001}, 8'hFF, 1'b0);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    beat({32'h0, 32'hF000_0014}, 8'h0F, 1'b1);
    cycles(3);
    check("rst_mid_cpl", {131'd0, tx_has_data}, 132'd0);
    check("rst_mid_drop", {116'd0, drop_cnt}, 132'd0);
    mrd(32'hF000_0014, 8'h42, 32'h0000_0001);
    cycles(2);
    check("post_rst_has", {131'd0, tx_has_data}, 132'd1);
    pop_check("post_rst", cpl(32'hDEAD_BEEF, 16'h0100, 8'h42, 32'hF000_0014));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
